ecg_buffer_ctrl: RTL and testbench

//  Owns the single-port 256x8 ECG sample RAM feeding the waveform renderer and arbitrates it between
//  a streaming sample source (valid/ready) and the pixel-rate display read. Display reads own the RAM

---
 rtl/ecg_buffer_ctrl.sv | 166 ++++++++++++++++
 tb/tb_ecg_buffer_ctrl.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ecg_buffer_ctrl.sv
// ---------------------------------------------------------------------------
// ecg_buffer_ctrl
//
// Owns the single-port ECG sample RAM that feeds the waveform renderer and
// shares it between a streaming sample source and the pixel-rate display
// read. During active video the display owns the RAM. Incoming samples are
// written only during blanking. At each frame start a scroll base is latched
// so that the trace shows the most recent VIS samples.
//
// Ports
//   clk, reset            pixel clock, synchronous active-high reset
//   x, y                  VGA timing counters (column / row)
//   frame_start           one-cycle pulse at the start of vertical blanking
//   pause                 1 = freeze the scroll base (writes continue)
//   in_valid/in_data      sample stream from the source
//   in_ready              combinational acceptance, low during video/latch
//   mem_en/we/addr/wdata  single-port RAM control
//   mem_rdata             RAM read data, one cycle after a read
//   sample_out/sample_vld sample for the column presented two cycles earlier
//   wr_ptr                next write address
//   fill_count            samples written since reset, saturating at DEPTH
// ---------------------------------------------------------------------------
module ecg_buffer_ctrl #(
    parameter int AW       = 8,
    parameter int DW       = 8,
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int XSHIFT   = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [9:0]    x,
    input  logic [9:0]    y,
    input  logic          frame_start,
    input  logic          pause,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    output logic          in_ready,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic [DW-1:0] sample_out,
    output logic          sample_vld,
    output logic [AW-1:0] wr_ptr,
    output logic [AW:0]   fill_count
);

    typedef logic [AW-1:0] addr_t;
    typedef logic [AW:0]   cnt_t;

    localparam int         DEPTH   = 2 ** AW;
    localparam int         VIS     = H_ACTIVE >> XSHIFT;
    localparam logic [9:0] H_ACT   = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT   = 10'(V_ACTIVE);
    localparam cnt_t       DEPTH_C = cnt_t'(DEPTH);
    localparam cnt_t       VIS_C   = cnt_t'(VIS);
    localparam addr_t      VIS_A   = addr_t'(VIS);
    localparam addr_t      ONE_A   = addr_t'(1);
    localparam cnt_t       ONE_C   = cnt_t'(1);

    typedef enum logic [1:0] {
        S_BLANK   = 2'd0,
        S_DISPLAY = 2'd1,
        S_LATCH   = 2'd2
    } state_t;

    // Fill counter increment that sticks at DEPTH once the buffer is full.
    function automatic cnt_t sat_inc(input cnt_t c);
        return (c >= DEPTH_C) ? DEPTH_C : c + ONE_C;
    endfunction

    // Sample column shown at pixel column px.
    function automatic addr_t col_of(input logic [9:0] px);
        logic [9:0] xs;
        xs = px >> XSHIFT;
        return addr_t'(xs);
    endfunction

    state_t  state_q, state_d;
    addr_t   wr_ptr_q, wr_ptr_d;
    cnt_t    fill_q, fill_d;
    addr_t   scroll_q, scroll_d;
    logic    vld_p1_q, vld_p1_d;
    logic    vld_p2_q, vld_p2_d;
    logic [DW-1:0] sample_p2_q, sample_p2_d;

    logic    active;
    logic    wr_fire;
    logic    rd_fire;
    addr_t   rd_addr;

    always_comb begin
        active   = (x < H_ACT) && (y < V_ACT);
        in_ready = !active && (state_q != S_LATCH);
        // A handshake seen while reset is asserted is dropped, not written.
        wr_fire  = in_valid && in_ready && !reset;
        rd_fire  = active && !reset;
        rd_addr  = scroll_q + col_of(x);

        mem_en    = wr_fire || rd_fire;
        mem_we    = wr_fire;
        mem_addr  = wr_fire ? wr_ptr_q : (rd_fire ? rd_addr : '0);
        mem_wdata = wr_fire ? in_data : '0;
    end

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        fill_d      = fill_q;
        scroll_d    = scroll_q;

        unique case (state_q)
            // frame_start only counts when it arrives in settled blanking.
            S_BLANK:   state_d = (frame_start && !active) ? S_LATCH :
                                 (active ? S_DISPLAY : S_BLANK);
            S_DISPLAY: state_d = active ? S_DISPLAY : S_BLANK;
            S_LATCH:   state_d = active ? S_DISPLAY : S_BLANK;
            default:   state_d = S_BLANK;
        endcase

        if (wr_fire) begin
            wr_ptr_d = wr_ptr_q + ONE_A;
            fill_d   = sat_inc(fill_q);
        end

        // Until VIS samples exist the trace starts at address 0; afterwards
        // it ends at the newest sample (modulo-DEPTH subtraction).
        if (state_q == S_LATCH && !pause) begin
            scroll_d = (fill_q >= VIS_C) ? (wr_ptr_q - VIS_A) : '0;
        end

        // p1: read issued last cycle, mem_rdata valid now
        vld_p1_d    = rd_fire;
        // p2: registered output sample
        vld_p2_d    = vld_p1_q;
        sample_p2_d = vld_p1_q ? mem_rdata : sample_p2_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_BLANK;
            wr_ptr_q    <= '0;
            fill_q      <= '0;
            scroll_q    <= '0;
            vld_p1_q    <= 1'b0;
            vld_p2_q    <= 1'b0;
            sample_p2_q <= '0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            fill_q      <= fill_d;
            scroll_q    <= scroll_d;
            vld_p1_q    <= vld_p1_d;
            vld_p2_q    <= vld_p2_d;
            sample_p2_q <= sample_p2_d;
        end
    end

    assign sample_out = sample_p2_q;
    assign sample_vld = vld_p2_q;
    assign wr_ptr     = wr_ptr_q;
    assign fill_count = fill_q;

endmodule

// File: tb/tb_ecg_buffer_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ecg_buffer_ctrl
//
// Scoreboard bench for ecg_buffer_ctrl. Stimulus pushes expected RAM writes
// and expected display samples into queues; a monitor on the falling edge
// pops and compares whenever the DUT writes or presents sample_vld. A small
// behavioural RAM supplies mem_rdata.
// ---------------------------------------------------------------------------
module tb_ecg_buffer_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [9:0] x, y;
    logic       frame_start, pause;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       mem_en, mem_we;
    logic [7:0] mem_addr, mem_wdata, mem_rdata;
    logic [7:0] sample_out;
    logic       sample_vld;
    logic [7:0] wr_ptr;
    logic [8:0] fill_count;

    always #5 clk = ~clk;

    ecg_buffer_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .x          (x),
        .y          (y),
        .frame_start(frame_start),
        .pause      (pause),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .sample_out (sample_out),
        .sample_vld (sample_vld),
        .wr_ptr     (wr_ptr),
        .fill_count (fill_count)
    );

    // Behavioural single-port RAM, one-cycle read latency.
    logic [7:0] ram [256];
    always @(posedge clk) begin
        if (mem_en && mem_we)  ram[mem_addr] <= mem_wdata;
        if (mem_en && !mem_we) mem_rdata     <= ram[mem_addr];
    end

    logic [15:0] wq[$];
    logic [7:0]  sq[$];
    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: checks every RAM write and every presented sample in order.
    logic [15:0] e_w;
    logic [7:0]  e_s;
    always @(negedge clk) begin
        if (mem_en === 1'b1 && mem_we === 1'b1) begin
            if (wq.size() == 0) chk("unexpected_write", 1, 0);
            else begin
                e_w = wq.pop_front();
                chk("wr_addr", int'(mem_addr), int'(e_w[15:8]));
                chk("wr_data", int'(mem_wdata), int'(e_w[7:0]));
            end
        end
        if (sample_vld === 1'b1) begin
            if (sq.size() == 0) chk("unexpected_sample", 1, 0);
            else begin
                e_s = sq.pop_front();
                chk("sample_out", int'(sample_out), int'(e_s));
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        x = 10'd700; y = 10'd0;
        in_valid = 1'b1; in_data = d;
        wq.push_back({a, d});
        @(negedge clk);
        next_cycle();
    endtask

    task automatic rd(input int xv, input logic [7:0] ea, input logic [7:0] ed);
        x = 10'(xv); y = 10'd0; in_valid = 1'b0;
        sq.push_back(ed);
        @(negedge clk);
        chk("rd_addr", int'(mem_addr), int'(ea));
        chk("rd_no_we", int'(mem_we), 0);
        next_cycle();
    endtask

    task automatic blank(input int n);
        x = 10'd700; y = 10'd0; in_valid = 1'b0;
        repeat (n) begin
            @(negedge clk);
            next_cycle();
        end
    endtask

    task automatic frame();
        x = 10'd700; y = 10'd480; in_valid = 1'b0; frame_start = 1'b1;
        @(negedge clk);
        next_cycle();
        frame_start = 1'b0;
        @(negedge clk);
        chk("latch_in_ready", int'(in_ready), 0);
        next_cycle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        // 1: reset, with a handshake offered that must be discarded
        reset = 1'b1; x = 10'd700; y = 10'd0; frame_start = 1'b0; pause = 1'b0;
        in_valid = 1'b1; in_data = 8'h55;
        next_cycle();
        x = 10'd0;
        @(negedge clk);
        chk("rst_in_ready_active", int'(in_ready), 0);
        chk("rst_mem_en_active", int'(mem_en), 0);
        next_cycle();
        x = 10'd700;
        @(negedge clk);
        chk("rst_in_ready_blank", int'(in_ready), 1);
        chk("rst_mem_en", int'(mem_en), 0);
        chk("rst_mem_we", int'(mem_we), 0);
        chk("rst_wr_ptr", int'(wr_ptr), 0);
        chk("rst_fill", int'(fill_count), 0);
        chk("rst_sample_vld", int'(sample_vld), 0);
        next_cycle();
        reset = 1'b0;

        // 2: three back-to-back writes in blanking
        wr(8'd0, 8'h11);
        wr(8'd1, 8'h22);
        wr(8'd2, 8'h33);
        in_valid = 1'b0;
        @(negedge clk);
        chk("t2_wr_ptr", int'(wr_ptr), 3);
        chk("t2_fill", int'(fill_count), 3);
        next_cycle();

        // 3: sample offered during video is held until blanking
        x = 10'd0; y = 10'd0; in_valid = 1'b1; in_data = 8'h44;
        repeat (2) begin
            sq.push_back(8'h11);
            @(negedge clk);
            chk("t3_in_ready", int'(in_ready), 0);
            chk("t3_mem_we", int'(mem_we), 0);
            chk("t3_rd_addr", int'(mem_addr), 0);
            next_cycle();
        end
        x = 10'd700;
        wq.push_back({8'd3, 8'h44});
        @(negedge clk);
        chk("t3_in_ready_blank", int'(in_ready), 1);
        next_cycle();
        in_valid = 1'b0;
        @(negedge clk);
        chk("t3_wr_ptr", int'(wr_ptr), 4);
        next_cycle();
        // Fewer than VIS samples: scroll base stays at 0.
        frame();
        rd(0, 8'd0, 8'h11);
        blank(3);

        // 4: fresh reset, RAM[k]=k, sweep x=0..7
        reset = 1'b1;
        blank(2);
        reset = 1'b0;
        for (int k = 0; k < 256; k++) wr(8'(k), 8'(k));
        in_valid = 1'b0;
        @(negedge clk);
        chk("t4_wr_ptr", int'(wr_ptr), 0);
        chk("t4_fill", int'(fill_count), 256);
        next_cycle();
        blank(2);
        for (int j = 0; j < 8; j++) begin
            x = 10'(j); y = 10'd0;
            sq.push_back(8'(j >> 2));
            @(negedge clk);
            chk("t4_rd_addr", int'(mem_addr), j >> 2);
            chk("t4_lag_vld", int'(sample_vld), (j >= 2) ? 1 : 0);
            next_cycle();
        end
        blank(3);

        // 5: 300 samples in total, then latch the scroll base
        for (int k = 256; k < 300; k++) wr(8'(k), 8'(k));
        in_valid = 1'b0;
        @(negedge clk);
        chk("t5_wr_ptr", int'(wr_ptr), 44);
        chk("t5_fill_sat", int'(fill_count), 256);
        next_cycle();
        frame();
        rd(0, 8'd140, 8'd140);
        rd(4, 8'd141, 8'd141);
        blank(3);

        // 6: ten more writes; frame_start during video is ignored
        for (int k = 300; k < 310; k++) wr(8'(k), 8'(k));
        in_valid = 1'b0;
        @(negedge clk);
        chk("t6_wr_ptr", int'(wr_ptr), 54);
        next_cycle();
        frame_start = 1'b1;
        rd(0, 8'd140, 8'd140);
        frame_start = 1'b0;
        rd(4, 8'd141, 8'd141);
        blank(1);
        // Paused frame: scroll base holds.
        pause = 1'b1;
        frame();
        rd(0, 8'd140, 8'd140);
        blank(1);
        // Unpaused frame: 54-160 mod 256 = 150.
        pause = 1'b0;
        frame();
        rd(0, 8'd150, 8'd150);
        rd(4, 8'd151, 8'd151);
        blank(4);

        chk("drain_writes", wq.size(), 0);
        chk("drain_samples", sq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
